alu_exec_unit: RTL and testbench

- Execution-stage ALU that consumes the 6-bit ALUctrl code produced by the ALU controller and returns a registered result.
- Most operations complete in a single cycle.
- MULTU (code 'h13) runs a multi-cycle shift-add multiplier into HI/LO registers and stalls the pipeline via busy.
- Sits between the ID/EX pipeline register and the EX/MEM register; HI/LO are exposed for move-from-hi/lo datapath muxing.

---
 rtl/alu_exec_unit_if.sv | 25 ++
 rtl/alu_exec_unit.sv | 137 +++++++++++++
 tb/tb_alu_exec_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Operation request/response bundle between the ID/EX stage and alu_exec_unit.
// The master drives the request; the slave (the ALU) returns result, flags and HI/LO.
interface alu_exec_unit_if;
   logic        start;
   logic [5:0]  ALUctrl;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [31:0] result;
   logic        result_valid;
   logic        zero;
   logic        ovf;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, ALUctrl, opA, opB,
      input  result, result_valid, zero, ovf, busy, hi, lo
   );

   modport slave (
      input  start, ALUctrl, opA, opB,
      output result, result_valid, zero, ovf, busy, hi, lo
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle ops plus a 32-step shift-add MULTU into HI/LO.
// Define MULT_EARLY_EXIT_EN to end a multiply once the remaining multiplier bits are zero.
module alu_exec_unit #(
   parameter logic signed [31:0] CLIP_LO = 32'sd0,
   parameter logic signed [31:0] CLIP_HI = 32'sd255
) (
   input logic           clk,
   input logic           reset,
   alu_exec_unit_if.slave bus
);

   localparam logic [5:0] OP_MULTU = 6'h13;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t      state, state_next;
   logic [31:0] mcand, mplier;
   logic [63:0] acc, acc_next;
   logic [32:0] step_sum;
   logic [6:0]  shamt;
   logic [5:0]  cnt;
   logic        early, mul_finish, accept;
   logic [31:0] alu_res, sum;
   logic        alu_ovf;

   // A new request is taken whenever no multiply is running, including the DONE cycle.
   assign accept   = bus.start && (state != S_MUL);
   assign bus.busy = (state == S_MUL);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      sum     = bus.opA + bus.opB;
      case (bus.ALUctrl)
         6'h00: alu_res = bus.opA & bus.opB;
         6'h01: alu_res = bus.opA | bus.opB;
         6'h02: begin
            alu_res = sum;
            alu_ovf = (bus.opA[31] == bus.opB[31]) && (sum[31] != bus.opA[31]);
         end
         6'h03: alu_res = sum;
         6'h04: alu_res = bus.opA ^ bus.opB;
         6'h06: alu_res = bus.opA - bus.opB;
         6'h07: alu_res = {31'd0, $signed(bus.opA) < $signed(bus.opB)};
         6'h08: alu_res = {31'd0, bus.opA < bus.opB};
         6'h09: alu_res = {bus.opB[15:0], 16'h0000};
         6'h0A: alu_res = bus.opB << 1;
         6'h0B: alu_res = bus.opB << 2;
         6'h0C: alu_res = bus.opB << 8;
         6'h0D: alu_res = bus.opB >> 1;
         6'h0E: alu_res = bus.opB >> 2;
         6'h0F: alu_res = bus.opB >> 8;
         6'h10: alu_res = $signed(bus.opB) >>> 1;
         6'h11: alu_res = $signed(bus.opB) >>> 2;
         6'h12: alu_res = $signed(bus.opB) >>> 8;
         6'h14: begin
            if ($signed(bus.opA) < CLIP_LO)      alu_res = CLIP_LO;
            else if ($signed(bus.opA) > CLIP_HI) alu_res = CLIP_HI;
            else                                 alu_res = bus.opA;
         end
         default: alu_res = '0;
      endcase
   end

   // One shift-add step; bit 32 of step_sum keeps the carry out of the upper half.
   always_comb begin
      step_sum = {1'b0, acc[63:32]} + (mplier[0] ? {1'b0, mcand} : 33'd0);
      shamt    = 7'd32 - {1'b0, cnt};
`ifdef MULT_EARLY_EXIT_EN
      early    = (mplier == 32'd0);
`else
      early    = 1'b0;
`endif
      acc_next   = early ? (acc >> shamt) : {step_sum, acc[31:1]};
      mul_finish = early || (cnt == 6'd31);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE: state_next = (accept && bus.ALUctrl == OP_MULTU) ? S_MUL : S_IDLE;
         S_MUL:          if (mul_finish) state_next = S_DONE;
         default:        state_next = S_IDLE;
      endcase
   end

   // NOTE: reset is synchronous; it also drops any in-flight partial product.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.result       <= '0;
         bus.result_valid <= 1'b0;
         bus.zero         <= 1'b1;
         bus.ovf          <= 1'b0;
         bus.hi           <= '0;
         bus.lo           <= '0;
         acc              <= '0;
         mcand            <= '0;
         mplier           <= '0;
         cnt              <= '0;
      end else begin
         bus.result_valid <= 1'b0;
         if (state == S_MUL) begin
            acc    <= acc_next;
            mplier <= mplier >> 1;
            cnt    <= cnt + 6'd1;
            if (mul_finish) begin
               bus.hi           <= acc_next[63:32];
               bus.lo           <= acc_next[31:0];
               bus.result       <= acc_next[31:0];
               bus.zero         <= (acc_next[31:0] == 32'd0);
               bus.ovf          <= 1'b0;
               bus.result_valid <= 1'b1;
            end
         end else if (accept) begin
            if (bus.ALUctrl == OP_MULTU) begin
               mcand  <= bus.opA;
               mplier <= bus.opB;
               acc    <= '0;
               cnt    <= '0;
            end else begin
               bus.result       <= alu_res;
               bus.zero         <= (alu_res == 32'd0);
               bus.ovf          <= alu_ovf;
               bus.result_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed ops, scoreboard of expected results
// keyed by completion cycle, multiply latency/stall behaviour and reset abort.
module tb_alu_exec_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_exec_unit_if bus();

   alu_exec_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
   } exp_t;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ovf;
   } vec_t;

`ifdef MULT_EARLY_EXIT_EN
   localparam int LAT_9X2 = 4;
   localparam int LAT_ZERO = 2;
`else
   localparam int LAT_9X2 = 33;
   localparam int LAT_ZERO = 33;
`endif

   localparam int NV = 28;

   exp_t        sb[$];
   vec_t        tbl[NV];
   int          cyc = 0;
   int          passes = 0;
   int          fails = 0;
   int          total = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start   = 1'b1;
      bus.ALUctrl = op;
      bus.opA     = a;
      bus.opB     = b;
   endtask

   task automatic push(input logic [31:0] res, input logic ovf, input int lat);
      exp_t e;
      e.res = res; e.ovf = ovf; e.hi = m_hi; e.lo = m_lo; e.due = cyc + lat;
      sb.push_back(e);
   endtask

   task automatic push_mul(input logic [31:0] a, input logic [31:0] b, input int lat);
      logic [63:0] p;
      p    = {32'd0, a} * {32'd0, b};
      m_hi = p[63:32];
      m_lo = p[31:0];
      push(m_lo, 1'b0, lat);
   endtask

   // Advance to the next falling edge and compare whatever the DUT produced there.
   task automatic cycle();
      exp_t e;
      logic due;
      @(negedge clk);
      cyc++;
      due = (sb.size() > 0) && (sb[0].due == cyc);
      chk("result_valid", {63'd0, bus.result_valid}, {63'd0, due});
      if (due) begin
         e = sb.pop_front();
         chk("result", {32'd0, bus.result}, {32'd0, e.res});
         chk("zero",   {63'd0, bus.zero},   {63'd0, e.res == 32'd0});
         chk("ovf",    {63'd0, bus.ovf},    {63'd0, e.ovf});
         chk("hi",     {32'd0, bus.hi},     {32'd0, e.hi});
         chk("lo",     {32'd0, bus.lo},     {32'd0, e.lo});
      end
   endtask

   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int lat);
      issue(6'h13, a, b);
      push_mul(a, b, lat);
      cycle();
      bus.start = 1'b0;
      repeat (lat) cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl = '{
         '{6'h02, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1},
         '{6'h07, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0},
         '{6'h08, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0},
         '{6'h12, 32'h00000000, 32'h80000000, 32'hFF800000, 1'b0},
         '{6'h14, 32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0},
         '{6'h14, 32'h0000012C, 32'h00000000, 32'h000000FF, 1'b0},
         '{6'h14, 32'h0000004D, 32'h00000000, 32'h0000004D, 1'b0},
         '{6'h00, 32'hF0F000FF, 32'h0FF0FF0F, 32'h00F0000F, 1'b0},
         '{6'h01, 32'hF0F000FF, 32'h0FF0FF0F, 32'hFFF0FFFF, 1'b0},
         '{6'h04, 32'hF0F000FF, 32'h0FF0FF0F, 32'hFF00FFF0, 1'b0},
         '{6'h06, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0},
         '{6'h03, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
         '{6'h02, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
         '{6'h02, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1},
         '{6'h09, 32'h00000000, 32'h1234ABCD, 32'hABCD0000, 1'b0},
         '{6'h0A, 32'h00000000, 32'h80000001, 32'h00000002, 1'b0},
         '{6'h0B, 32'h00000000, 32'h00000003, 32'h0000000C, 1'b0},
         '{6'h0C, 32'h00000000, 32'h12345678, 32'h34567800, 1'b0},
         '{6'h0D, 32'h00000000, 32'h80000001, 32'h40000000, 1'b0},
         '{6'h0E, 32'h00000000, 32'h00000010, 32'h00000004, 1'b0},
         '{6'h0F, 32'h00000000, 32'h80000000, 32'h00800000, 1'b0},
         '{6'h10, 32'h00000000, 32'h80000001, 32'hC0000000, 1'b0},
         '{6'h11, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFC, 1'b0},
         '{6'h05, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0},
         '{6'h3F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0},
         '{6'h14, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0},
         '{6'h14, 32'h7FFFFFFF, 32'h00000000, 32'h000000FF, 1'b0},
         '{6'h06, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0}
      };

      reset = 1'b1;
      bus.start = 1'b0; bus.ALUctrl = '0; bus.opA = '0; bus.opB = '0;
      repeat (3) @(negedge clk);
      chk("rst_result",       {32'd0, bus.result},       64'd0);
      chk("rst_result_valid", {63'd0, bus.result_valid}, 64'd0);
      chk("rst_zero",         {63'd0, bus.zero},         64'd1);
      chk("rst_ovf",          {63'd0, bus.ovf},          64'd0);
      chk("rst_busy",         {63'd0, bus.busy},         64'd0);
      chk("rst_hi",           {32'd0, bus.hi},           64'd0);
      chk("rst_lo",           {32'd0, bus.lo},           64'd0);
      reset = 1'b0;

      // Back-to-back single-cycle ops, one per cycle.
      for (int i = 0; i < NV; i++) begin
         issue(tbl[i].op, tbl[i].a, tbl[i].b);
         push(tbl[i].res, tbl[i].ovf, 1);
         cycle();
      end
      bus.start = 1'b0;
      cycle();

      // Full-width multiply; a start during busy must be ignored.
      issue(6'h13, 32'hFFFFFFFF, 32'hFFFFFFFF);
      push_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      for (int k = 1; k <= 32; k++) begin
         cycle();
         chk("mul_busy", {63'd0, bus.busy}, 64'd1);
         if (k == 5) issue(6'h00, 32'hFFFFFFFF, 32'hFFFFFFFF);
         else        bus.start = 1'b0;
      end
      cycle();
      chk("mul_busy_done", {63'd0, bus.busy}, 64'd0);
      chk("mul_hi_const",  {32'd0, bus.hi}, {32'd0, 32'hFFFFFFFE});
      chk("mul_lo_const",  {32'd0, bus.lo}, {32'd0, 32'h00000001});
      cycle();

      run_mul(32'd9, 32'd2, LAT_9X2);
      run_mul(32'h12345678, 32'd0, LAT_ZERO);

      // Single-cycle op must leave HI/LO alone.
      issue(6'h04, 32'h0000FFFF, 32'h00FF00FF);
      push(32'h00FFFF00, 1'b0, 1);
      cycle();
      bus.start = 1'b0;
      cycle();

      // Reset in the middle of a multiply aborts it.
      run_mul(32'd7, 32'd6, 33);
      issue(6'h13, 32'd3, 32'd5);
      cycle();
      bus.start = 1'b0;
      repeat (9) cycle();
      reset = 1'b1;
      m_hi = '0;
      m_lo = '0;
      cycle();
      chk("abort_busy",   {63'd0, bus.busy},   64'd0);
      chk("abort_hi",     {32'd0, bus.hi},     64'd0);
      chk("abort_lo",     {32'd0, bus.lo},     64'd0);
      chk("abort_result", {32'd0, bus.result}, 64'd0);
      chk("abort_zero",   {63'd0, bus.zero},   64'd1);
      reset = 1'b0;
      repeat (40) cycle();
      chk("abort_no_pulse_busy", {63'd0, bus.busy}, 64'd0);

      issue(6'h03, 32'd2, 32'd2);
      push(32'd4, 1'b0, 1);
      cycle();
      bus.start = 1'b0;
      cycle();

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
